fp32_to_int32: RTL and testbench
================================

Name: fp32_to_int32

Overview:
- Two-stage pipelined converter from IEEE-754 binary32 to two's-complement int32, with selectable rounding and saturation.
- It is the decode-direction counterpart of the leading-zero-count and normalize path used for integer-to-float conversion. Instead of counting zeros and shifting left, it takes the position from the exponent and right-aligns the mantissa.
- It sits in the lane datapath between the FP unit result bus and the integer writeback, with valid/ready handshakes on both sides.

Parameters:
- NAN_VAL, 32'h7FFF_FFFF: integer result driven for NaN inputs.
- POS_SAT, 32'h7FFF_FFFF: result for positive overflow and +Inf.
- NEG_SAT, 32'h8000_0000: result for negative overflow and -Inf.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- I_Valid  in  1  input operand valid.
- I_Data  in  32  binary32 operand.
- I_RndMode  in  1  rounding mode: 0 = round to nearest even (RNE), 1 = round toward zero (RTZ); captured with I_Data.
- O_Ready  out  1  converter can accept an operand this cycle.
- O_Valid  out  1  result valid.
- O_Data  out  32  int32 result.
- O_Inexact  out  1  a nonzero fraction was discarded.
- O_Invalid  out  1  NaN, Inf or out-of-range input (result saturated).
- I_Ready  in  1  downstream accepts the result.

Behaviour:
- Reset (asynchronous, active-low): both stage-valid flags clear. O_Valid=0, O_Data=0, O_Inexact=0, O_Invalid=0. Reset asserted mid-operation discards all in-flight operands; no partial result is emitted after release.
- Transfers: an input transfer occurs on I_Valid & O_Ready; an output transfer occurs on O_Valid & I_Ready.
- Pipeline control: S2 advances when !S2.valid | I_Ready. S1 advances when S2 advances or !S1.valid. O_Ready = S1 advance condition. This gives full throughput of one operand per cycle with no bubbles while I_Ready=1.
- Latency: exactly 2 cycles from input transfer to O_Valid with no backpressure.
- While O_Valid & !I_Ready, O_Data, O_Inexact and O_Invalid are held stable.
- Field decode: s=I_Data[31], e=[30:23], f=[22:0], m={e!=0,f} (24b), E=e-127.
- S1 classification, priority order:
  1. NaN: e=255 & f!=0.
  2. Inf: e=255 & f=0.
  3. Exact minimum: s=1, e=158, f=0 → NEG_SAT, invalid=0.
  4. Overflow: e>=158 → invalid=1.
  5. Tiny: e<=125, including zero and denormals → magnitude 0.
  6. Normal: everything else.
- S1 alignment, normal path:
  - If E>=23, magnitude = m<<(E-23) with shift 0..7; exact.
  - If E<23, magnitude = m>>(23-E) with shift 1..24. Guard = last bit shifted out; sticky = OR of all lower shifted-out bits.
  - Magnitude width is 31 bits.
- S1 tiny path: magnitude=0. Guard = (e==126). Sticky = (e==126) ? (f!=0) : (e!=0 | f!=0).
- S2 rounding: RNE increments when guard & (sticky | lsb). RTZ never increments. Inexact = guard | sticky.
  - A rounding carry cannot exceed 2^31-1, since rounding occurs only for E<=22.
- S2 sign: the result is negated when s=1. A result of -0 yields 0.
- S2 flags: O_Invalid=1 for NaN, Inf and overflow. In those cases O_Inexact=0 and the result is NAN_VAL, POS_SAT or NEG_SAT by sign. Positive zero and negative zero give 0 with both flags clear.

Decomposition:
- Shared package pkg_fpcvt:
  - binary32 field widths and bias constant 127.
  - rounding-mode enum (RNE=0, RTZ=1).
  - class enum {CLS_NORM, CLS_TINY, CLS_NAN, CLS_INF, CLS_OVF, CLS_MIN}.
  - packed S1 struct {valid, sign, cls, mag[30:0], guard, sticky, rnd}.
- One sub-module, align_shift_sticky: combinational 24-bit mantissa with signed shift amount in, giving a 31-bit magnitude plus guard and sticky. The same unit is reused by later fixed-point conversions.

Test Plan:
- Rounding of 1.5: 0x3FC00000 with RNE → 0x00000002, inexact=1. With RTZ → 0x00000001, inexact=1.
- Ties to even: 0x40200000 (2.5) with RNE → 2. 0xC0200000 (-2.5) → 0xFFFFFFFE. 0x3F000000 (0.5) → 0, inexact=1. 0x3F000001 → 1. 0x00000001 (denormal) → 0, inexact=1.
- Range limits: 0xCF000000 → 0x80000000 with invalid=0. 0x4F000000 → 0x7FFFFFFF with invalid=1. 0x7FC00000 → NAN_VAL with invalid=1. 0xFF800000 → 0x80000000 with invalid=1. 0x4EFFFFFF → 0x7FFFFF80 exact.
- Throughput: 8 back-to-back operands with I_Ready=1 → first O_Valid 2 cycles after the first transfer, then one result per cycle, in order.
- Backpressure: stream 4 operands and drop I_Ready for 3 cycles after the first result. Required response: O_Data held stable, O_Ready=0 once both stages are full, and all 4 results arrive in order with no loss or duplication.
- Reset mid-stream: assert reset while S1 and S2 are both valid → O_Valid=0 immediately (asynchronous). After release, the first result corresponds to the first operand accepted after release.

Source files
------------

// File: rtl/fp32_to_int32_pkg.sv
// Shared binary32 field layout, rounding/class enums and the pipeline stage-1 record
// used by the float-to-integer conversion path.
package pkg_fpcvt;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 1;
    localparam int MAG_W   = 31;
    localparam int BIAS    = 127;

    localparam logic [EXP_W-1:0] EXP_SPECIAL  = 8'hFF;
    localparam logic [EXP_W-1:0] EXP_INT_MIN  = 8'(BIAS + 31);
    localparam logic [EXP_W-1:0] EXP_TINY_MAX = 8'(BIAS - 2);

    typedef enum logic {
        RNE = 1'b0,
        RTZ = 1'b1
    } rnd_mode_e;

    typedef enum logic [2:0] {
        CLS_NORM,
        CLS_TINY,
        CLS_NAN,
        CLS_INF,
        CLS_OVF,
        CLS_MIN
    } cls_e;

    typedef struct packed {
        logic             valid;
        logic             sign;
        cls_e             cls;
        logic [MAG_W-1:0] mag;
        logic             guard;
        logic             sticky;
        rnd_mode_e        rnd;
    } s1_t;

    // Aligner shift for a biased exponent: positive = left shift of the 24-bit mantissa.
    function automatic logic signed [5:0] align_shift(input logic [EXP_W-1:0] e);
        return $signed(6'(e - 8'(BIAS + FRAC_W)));
    endfunction

endpackage

// File: rtl/fp32_to_int32_if.sv
// Operand/result handshake bundle between the FP result bus and the integer writeback.
interface fp32_to_int32_if;

    logic        I_Valid;
    logic [31:0] I_Data;
    logic        I_RndMode;
    logic        O_Ready;
    logic        O_Valid;
    logic [31:0] O_Data;
    logic        O_Inexact;
    logic        O_Invalid;
    logic        I_Ready;

    modport slave (
        input  I_Valid, I_Data, I_RndMode, I_Ready,
        output O_Ready, O_Valid, O_Data, O_Inexact, O_Invalid
    );

    modport master (
        output I_Valid, I_Data, I_RndMode, I_Ready,
        input  O_Ready, O_Valid, O_Data, O_Inexact, O_Invalid
    );

endinterface

// File: rtl/fp32_to_int32_align_shift_sticky.sv
// Right/left aligns a 24-bit mantissa into a 31-bit magnitude, collecting guard and sticky.
// Latency: combinational.
// Backpressure: none.
module align_shift_sticky (
    input  logic [23:0]       mant,
    input  logic signed [5:0] shamt,
    output logic [30:0]       mag,
    output logic              guard,
    output logic              sticky
);

    logic [47:0] ext;
    logic [5:0]  rs;

    always_comb begin
        mag    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        ext    = '0;
        rs     = '0;
        if (!shamt[5]) begin
            mag = {7'b0, mant} << shamt[2:0];
        end else begin
            // Bits falling below the binary point land in the low half of ext.
            rs     = -shamt;
            ext    = {mant, 24'b0} >> rs;
            mag    = {7'b0, ext[47:24]};
            guard  = ext[23];
            sticky = |ext[22:0];
        end
    end

endmodule

// File: rtl/fp32_to_int32.sv
// Converts binary32 to saturating int32 with RNE/RTZ rounding and inexact/invalid flags.
// Latency: 2 cycles (classify+align, then round+sign).
// Backpressure: stalls stage 2 on !I_Ready; O_Ready drops only when both stages are full.
module fp32_to_int32
    import pkg_fpcvt::*;
#(
    parameter logic [31:0] NAN_VAL = 32'h7FFF_FFFF,
    parameter logic [31:0] POS_SAT = 32'h7FFF_FFFF,
    parameter logic [31:0] NEG_SAT = 32'h8000_0000
) (
    input  logic           clock,
    input  logic           reset,
    fp32_to_int32_if.slave io
);

    s1_t s1_q, s1_d;
    logic        o_valid_q,   o_valid_d;
    logic [31:0] o_data_q,    o_data_d;
    logic        o_inexact_q, o_inexact_d;
    logic        o_invalid_q, o_invalid_d;

    logic s2_adv, s1_adv;

    logic              sgn;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;
    logic [MANT_W-1:0] mant;
    logic signed [5:0] shamt;
    cls_e              cls;
    logic [MAG_W-1:0]  al_mag;
    logic              al_guard, al_sticky;

    logic [MAG_W-1:0]  rmag;
    logic              rinc;
    logic [31:0]       sres;

    assign sgn   = io.I_Data[31];
    assign exp_f = io.I_Data[30:23];
    assign frac  = io.I_Data[22:0];
    assign mant  = {exp_f != '0, frac};
    assign shamt = align_shift(exp_f);

    align_shift_sticky u_align (
        .mant   (mant),
        .shamt  (shamt),
        .mag    (al_mag),
        .guard  (al_guard),
        .sticky (al_sticky)
    );

    always_comb begin
        s2_adv = !o_valid_q || io.I_Ready;
        s1_adv = s2_adv || !s1_q.valid;
    end

    always_comb begin
        cls = CLS_NORM;
        if (exp_f == EXP_SPECIAL && frac != '0)                 cls = CLS_NAN;
        else if (exp_f == EXP_SPECIAL)                          cls = CLS_INF;
        else if (sgn && exp_f == EXP_INT_MIN && frac == '0)     cls = CLS_MIN;
        else if (exp_f >= EXP_INT_MIN)                          cls = CLS_OVF;
        else if (exp_f <= EXP_TINY_MAX)                         cls = CLS_TINY;
    end

    always_comb begin
        s1_d = s1_q;
        if (s1_adv) begin
            s1_d.valid  = io.I_Valid;
            s1_d.sign   = sgn;
            s1_d.cls    = cls;
            s1_d.rnd    = rnd_mode_e'(io.I_RndMode);
            s1_d.mag    = '0;
            s1_d.guard  = 1'b0;
            s1_d.sticky = 1'b0;
            if (cls == CLS_NORM) begin
                s1_d.mag    = al_mag;
                s1_d.guard  = al_guard;
                s1_d.sticky = al_sticky;
            end else if (cls == CLS_TINY) begin
                // Below 0.5 the guard is always clear; 0.5..1.0 goes through the aligner.
                s1_d.sticky = (exp_f != '0) || (frac != '0);
            end
        end
    end

    always_comb begin
        rinc = (s1_q.rnd == RNE) && s1_q.guard && (s1_q.sticky || s1_q.mag[0]);
        rmag = s1_q.mag + MAG_W'(rinc);
        sres = s1_q.sign ? -{1'b0, rmag} : {1'b0, rmag};

        o_valid_d   = o_valid_q;
        o_data_d    = o_data_q;
        o_inexact_d = o_inexact_q;
        o_invalid_d = o_invalid_q;
        if (s2_adv) begin
            o_valid_d = s1_q.valid;
            if (s1_q.valid) begin
                o_inexact_d = 1'b0;
                o_invalid_d = 1'b0;
                unique case (s1_q.cls)
                    CLS_NAN: begin
                        o_data_d    = NAN_VAL;
                        o_invalid_d = 1'b1;
                    end
                    CLS_INF, CLS_OVF: begin
                        o_data_d    = s1_q.sign ? NEG_SAT : POS_SAT;
                        o_invalid_d = 1'b1;
                    end
                    CLS_MIN: o_data_d = NEG_SAT;
                    default: begin
                        o_data_d    = sres;
                        o_inexact_d = s1_q.guard || s1_q.sticky;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q        <= '0;
            o_valid_q   <= 1'b0;
            o_data_q    <= '0;
            o_inexact_q <= 1'b0;
            o_invalid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            o_valid_q   <= o_valid_d;
            o_data_q    <= o_data_d;
            o_inexact_q <= o_inexact_d;
            o_invalid_q <= o_invalid_d;
        end
    end

    assign io.O_Ready   = s1_adv;
    assign io.O_Valid   = o_valid_q;
    assign io.O_Data    = o_data_q;
    assign io.O_Inexact = o_inexact_q;
    assign io.O_Invalid = o_invalid_q;

endmodule

// File: tb/tb_fp32_to_int32.sv
// Bench for fp32_to_int32: directed corner vectors, throughput, backpressure, reset, random traffic.
module tb_fp32_to_int32;

    localparam logic [31:0] NAN_V = 32'h7FFF_FFFF;
    localparam logic [31:0] POS_V = 32'h7FFF_FFFF;
    localparam logic [31:0] NEG_V = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp32_to_int32_if io();

    fp32_to_int32 #(.NAN_VAL(NAN_V), .POS_SAT(POS_V), .NEG_SAT(NEG_V)) dut (
        .clock (clk),
        .reset (rst_n),
        .io    (io)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int out_cnt  = 0;
    logic [33:0] exp_q[$];
    int in_cyc[$];
    int out_cyc[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_out   = '0;
    logic        rnd_done   = 1'b0;

    typedef struct {
        logic [31:0] din;
        logic        rtz;
        logic [33:0] expv;   // {inexact, invalid, data}
    } vec_t;

    vec_t vecs[14] = '{
        '{32'h3FC00000, 1'b0, {2'b10, 32'h0000_0002}},
        '{32'h3FC00000, 1'b1, {2'b10, 32'h0000_0001}},
        '{32'h40200000, 1'b0, {2'b10, 32'h0000_0002}},
        '{32'hC0200000, 1'b0, {2'b10, 32'hFFFF_FFFE}},
        '{32'h3F000000, 1'b0, {2'b10, 32'h0000_0000}},
        '{32'h3F000001, 1'b0, {2'b10, 32'h0000_0001}},
        '{32'h00000001, 1'b0, {2'b10, 32'h0000_0000}},
        '{32'hCF000000, 1'b0, {2'b00, 32'h8000_0000}},
        '{32'h4F000000, 1'b0, {2'b01, 32'h7FFF_FFFF}},
        '{32'h7FC00000, 1'b0, {2'b01, 32'h7FFF_FFFF}},
        '{32'hFF800000, 1'b0, {2'b01, 32'h8000_0000}},
        '{32'h4EFFFFFF, 1'b0, {2'b00, 32'h7FFF_FF80}},
        '{32'h80000000, 1'b0, {2'b00, 32'h0000_0000}},
        '{32'hBFC00000, 1'b1, {2'b10, 32'hFFFF_FFFF}}
    };

    // Reference: value = m * 2^sh, split into integer part and discarded remainder.
    function automatic logic [33:0] ref_conv(input logic [31:0] x, input logic rtz);
        logic   s;
        int     e, sh, k;
        longint m, ip, rem, half, v;
        s = x[31];
        e = int'(x[30:23]);
        m = longint'(x[22:0]);
        if (e != 0) m += longint'(1) << 23;
        if (e == 255) return (x[22:0] != 0) ? {2'b01, NAN_V} : {2'b01, s ? NEG_V : POS_V};
        sh = ((e == 0) ? 1 : e) - 150;
        if (sh > 8) return {2'b01, s ? NEG_V : POS_V};
        if (sh >= 0) begin
            ip = m << sh; rem = 0; half = 1;
        end else begin
            k = -sh;
            if (k >= 40) begin
                ip = 0; rem = m; half = longint'(1) << 39;
            end else begin
                ip = m >> k; rem = m - (ip << k); half = longint'(1) << (k - 1);
            end
        end
        if (!rtz && (rem > half || (rem == half && ip[0]))) ip++;
        v = s ? -ip : ip;
        if (v > 64'sd2147483647 || v < -64'sd2147483648) return {2'b01, s ? NEG_V : POS_V};
        return {rem != 0, 1'b0, v[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(io.O_Valid), 64'(1));
                chk("hold_data", 64'({io.O_Inexact, io.O_Invalid, io.O_Data}), 64'(prev_out));
            end
            if (io.O_Valid && io.I_Ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $error("FAIL unexpected_output: observed %h expected none", io.O_Data);
                end else begin
                    chk("result", 64'({io.O_Inexact, io.O_Invalid, io.O_Data}), 64'(exp_q.pop_front()));
                    out_cyc.push_back(cyc);
                    out_cnt++;
                end
            end
            if (io.I_Valid && io.O_Ready) begin
                exp_q.push_back(ref_conv(io.I_Data, io.I_RndMode));
                in_cyc.push_back(cyc);
            end
            prev_stall = io.O_Valid && !io.I_Ready;
            prev_out   = {io.O_Inexact, io.O_Invalid, io.O_Data};
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operand.
    task automatic send(input logic [31:0] d, input logic r);
        int n = 0;
        io.I_Valid   = 1'b1;
        io.I_Data    = d;
        io.I_RndMode = r;
        @(negedge clk);
        while (!io.O_Ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accepted", 64'(io.O_Ready), 64'(1));
        @(posedge clk); #1;
        io.I_Valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 7))
            0, 1:    ;
            2:       x[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            default: x[30:23] = 8'($urandom_range(120, 160));
        endcase
        return x;
    endfunction

    initial begin
        int base;
        io.I_Valid   = 1'b0;
        io.I_Data    = '0;
        io.I_RndMode = 1'b0;
        io.I_Ready   = 1'b1;

        #12;
        chk("rst_valid",   64'(io.O_Valid),   64'(0));
        chk("rst_data",    64'(io.O_Data),    64'(0));
        chk("rst_inexact", 64'(io.O_Inexact), 64'(0));
        chk("rst_invalid", 64'(io.O_Invalid), 64'(0));
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            send(vecs[i].din, vecs[i].rtz);
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), 64'(io.O_Valid), 64'(0));
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 64'(io.O_Valid), 64'(1));
            chk($sformatf("vec%0d_out", i), 64'({io.O_Inexact, io.O_Invalid, io.O_Data}),
                64'(vecs[i].expv));
            @(posedge clk); #1;
        end
        drain("vec_drain");

        in_cyc.delete();
        out_cyc.delete();
        for (int i = 0; i < 8; i++) send(32'h3F800000 + 32'(i << 21), 1'b0);
        drain("tput_drain");
        chk("tput_count", 64'(out_cyc.size()), 64'(8));
        for (int i = 0; i < 8 && i < out_cyc.size(); i++)
            chk($sformatf("tput_lat%0d", i), 64'(out_cyc[i] - in_cyc[i]), 64'(2));

        base = out_cnt;
        fork
            begin
                for (int i = 0; i < 4; i++) send(32'h41000000 + 32'(i << 20), 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!io.O_Valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first", 64'(io.O_Valid), 64'(1));
                @(posedge clk); #1;
                io.I_Ready = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    chk($sformatf("bp_ready%0d", j), 64'(io.O_Ready), 64'(0));
                    @(posedge clk); #1;
                end
                io.I_Ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_count", 64'(out_cnt - base), 64'(4));

        send(32'h40400000, 1'b0);
        send(32'h40800000, 1'b0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 64'(io.O_Valid), 64'(0));
        chk("mid_rst_data",  64'(io.O_Data),  64'(0));
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        send(32'h41200000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_valid", 64'(io.O_Valid), 64'(1));
        chk("post_rst_data",  64'(io.O_Data),  64'(32'd10));
        @(posedge clk); #1;
        drain("rst_drain");

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_op(), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    io.I_Ready = ($urandom_range(0, 3) != 0);
                end
                io.I_Ready = 1'b1;
            end
        join
        drain("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
